gs232c_btb_assoc: RTL and testbench
===================================

GS232C_BTB_ASSOC -- requirements
Module: gs232c_btb_assoc

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning the number of fully-associative entries (a power of two, 4..64).
REQ-002 SHALL have parameter CNT_W, default 2, meaning the saturating-counter width (2..4).
REQ-003 SHALL derive localparam IW = log2(ENTRIES), meaning the entry-index width.
REQ-004 SHALL have ports (name  direction  width  meaning):
- clock  in  1  sole clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  invalidate all entries.
- lk_valid  in  1  lookup request.
- lk_pc  in  32  lookup fetch PC.
- lk_rsp  out  1  lookup response valid.
- lk_hit  out  1  tag hit.
- lk_idx  out  IW  hit entry index.
- lk_taken  out  1  counter MSB of the hit entry.
- lk_brop  out  1  stored conditional-branch flag.
- lk_jrop  out  1  stored indirect-jump flag.
- lk_target  out  32  predicted target, with [1:0]=0.
- up_valid  in  1  resolved-branch update.
- up_pc  in  32  branch PC.
- up_hit  in  1  lk_hit carried with the branch.
- up_idx  in  IW  lk_idx carried with the branch.
- up_taken  in  1  resolved direction.
- up_brop  in  1  branch is conditional.
- up_jrop  in  1  branch is indirect.
- up_target  in  32  resolved target.

Function
REQ-005 Each entry SHALL hold: valid, tag = pc[31:2], CNT_W counter, brop, jrop, and target[31:2].
REQ-006 Lookup SHALL have latency 1:
- lk_valid at edge N gives lk_rsp=1 during cycle N+1.
- lk_rsp=0 in any cycle after an edge with lk_valid=0.
REQ-007 Lookup SHALL compare lk_pc[31:2] against every valid tag.
- On a match, lk_hit=1 and lk_idx is the lowest matching index.
- On no match, lk_hit, lk_idx, lk_taken, lk_brop, lk_jrop and lk_target are all 0.
REQ-008 lk_taken SHALL equal the counter MSB of the hit entry; for a hit with brop=0, lk_taken SHALL be 1.
REQ-009 Lookup SHALL read pre-edge state: an update or flush at the same edge is not visible in that response.
REQ-010 flush sampled at edge N SHALL force lk_hit=0 for a lookup sampled at the same edge.
REQ-011 Update hit resolution:
- The entry is up_idx when up_hit=1 and entry up_idx is valid with a tag equal to up_pc[31:2].
- Otherwise the entry is the lowest valid entry whose tag matches up_pc[31:2].
- If neither applies, the update is a miss.
REQ-012 An update hit SHALL saturate the counter (+1 if up_taken, -1 otherwise, clamped to 0 and 2^CNT_W-1).
- If up_taken=1, it SHALL also write target, brop and jrop.
REQ-013 An update miss with up_taken=0 SHALL change no state.
REQ-014 An update miss with up_taken=1 SHALL allocate a victim entry:
- Victim is the lowest invalid entry if any, else the entry at round-robin pointer rr.
- Write valid=1, tag, target, brop and jrop.
- Initialise the counter to 2^(CNT_W-1) (weakly taken).
REQ-015 rr SHALL increment modulo ENTRIES only when it supplies the victim; wrap from ENTRIES-1 to 0.
REQ-016 flush SHALL clear all valid bits and set rr=0 at the next edge; flush has priority and the same-cycle update is dropped.
REQ-017 No two valid entries SHALL ever hold the same tag (guaranteed by REQ-011).

Reset
REQ-018 resetn=0 SHALL immediately, without a clock:
- clear all valid bits;
- set rr=0;
- drive lk_rsp, lk_hit, lk_idx, lk_taken, lk_brop, lk_jrop and lk_target to 0.
Counter, tag and target storage need not be reset.
REQ-019 resetn asserted mid-lookup SHALL drop the pending response; the first lookup after release behaves per REQ-006.

Verification
REQ-020 The bench SHALL cover these directed scenarios (ENTRIES=16, CNT_W=2):
- Reset, then lookup 0x1000 -> cycle later lk_rsp=1, lk_hit=0, all other outputs 0.
- Update pc=0x1000 miss, taken, brop=1, target=0x2000; then lookup 0x1000 -> lk_hit=1, lk_idx=0, lk_taken=1, lk_target=0x2000.
- Two not-taken updates on that entry (counter 2->1->0), then lookup -> lk_taken=0; two further not-taken updates keep the counter at 0.
- Allocate 17 distinct taken PCs -> entries 0..15 filled in order, the 17th replaces entry 0, rr=1.
- Update with up_hit=0 for a PC already held in entry 5 -> entry 5 counter updated, no second entry allocated.
- flush together with a taken-miss update and a lookup of a held PC -> that lookup misses, no allocation occurs, and all lookups afterwards miss.

Source files
------------

// File: rtl/gs232c_btb_assoc.sv
// gs232c_btb_assoc: fully-associative branch target buffer.
// Lookups return one cycle after they are sampled and reflect the table as it
// stood before that edge. Updates train a saturating direction counter on a
// hit, or allocate an entry on a taken miss: the lowest free entry is used
// first, otherwise the round-robin pointer picks the victim.
module gs232c_btb_assoc #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          flush,
  input  logic          lk_valid,
  input  logic [31:0]   lk_pc,
  output logic          lk_rsp,
  output logic          lk_hit,
  output logic [IW-1:0] lk_idx,
  output logic          lk_taken,
  output logic          lk_brop,
  output logic          lk_jrop,
  output logic [31:0]   lk_target,
  input  logic          up_valid,
  input  logic [31:0]   up_pc,
  input  logic          up_hit,
  input  logic [IW-1:0] up_idx,
  input  logic          up_taken,
  input  logic          up_brop,
  input  logic          up_jrop,
  input  logic [31:0]   up_target
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};

  // Entry storage. Only valid and rr are reset; everything else is qualified
  // by valid before it is ever looked at.
  logic [ENTRIES-1:0] valid;
  logic [29:0]        tag   [ENTRIES];
  logic [CNT_W-1:0]   cnt   [ENTRIES];
  logic [29:0]        tgt   [ENTRIES];
  logic [ENTRIES-1:0] brop_q;
  logic [ENTRIES-1:0] jrop_q;
  logic [IW-1:0]      rr;

  // Low PC/target bits are always zero by construction and are not stored.
  logic unused_low_bits;
  assign unused_low_bits = ^{lk_pc[1:0], up_pc[1:0], up_target[1:0]};

  // Lookup tag search: descending scan so the lowest matching index wins.
  logic          lk_match;
  logic [IW-1:0] lk_sel;
  always_comb begin
    lk_match = 1'b0;
    lk_sel   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == lk_pc[31:2])) begin
        lk_match = 1'b1;
        lk_sel   = IW'(i);
      end
    end
  end

  // Update-side search: lowest matching entry and lowest free entry.
  logic          up_match;
  logic [IW-1:0] up_sel;
  logic          any_free;
  logic [IW-1:0] free_sel;
  always_comb begin
    up_match = 1'b0;
    up_sel   = '0;
    any_free = 1'b0;
    free_sel = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tag[i] == up_pc[31:2])) begin
        up_match = 1'b1;
        up_sel   = IW'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_sel = IW'(i);
      end
    end
  end

  // Resolve which entry an update touches. The carried lookup index is only
  // trusted if that entry still holds this branch; otherwise fall back to the
  // search, which keeps tags unique across the table.
  logic             hint_ok;
  logic             up_found;
  logic [IW-1:0]    up_entry;
  logic [IW-1:0]    victim;
  logic             wr_hit;
  logic             wr_alloc;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  always_comb begin
    hint_ok  = up_hit && valid[up_idx] && (tag[up_idx] == up_pc[31:2]);
    up_found = hint_ok || up_match;
    up_entry = hint_ok ? up_idx : up_sel;
    victim   = any_free ? free_sel : rr;
    wr_hit   = up_valid && !flush && up_found;
    wr_alloc = up_valid && !flush && !up_found && up_taken;
    cnt_cur  = cnt[up_entry];
    cnt_next = cnt_cur;
    if (up_taken) begin
      if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
    end
  end

  // Valid bits and replacement pointer; flush wins over any update.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      rr    <= '0;
    end else if (flush) begin
      valid <= '0;
      rr    <= '0;
    end else if (wr_alloc) begin
      valid[victim] <= 1'b1;
      if (!any_free) rr <= rr + 1'b1;
    end
  end

  // Entry payload: train on hit, fill on allocation.
  always_ff @(posedge clock) begin
    if (wr_hit) begin
      cnt[up_entry] <= cnt_next;
      if (up_taken) begin
        tgt[up_entry]    <= up_target[31:2];
        brop_q[up_entry] <= up_brop;
        jrop_q[up_entry] <= up_jrop;
      end
    end
    if (wr_alloc) begin
      tag[victim]    <= up_pc[31:2];
      tgt[victim]    <= up_target[31:2];
      brop_q[victim] <= up_brop;
      jrop_q[victim] <= up_jrop;
      cnt[victim]    <= CNT_INIT;
    end
  end

  // Registered lookup response; a same-edge flush suppresses the hit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lk_rsp    <= 1'b0;
      lk_hit    <= 1'b0;
      lk_idx    <= '0;
      lk_taken  <= 1'b0;
      lk_brop   <= 1'b0;
      lk_jrop   <= 1'b0;
      lk_target <= '0;
    end else begin
      lk_rsp <= lk_valid;
      if (lk_valid && lk_match && !flush) begin
        lk_hit    <= 1'b1;
        lk_idx    <= lk_sel;
        lk_taken  <= brop_q[lk_sel] ? cnt[lk_sel][CNT_W-1] : 1'b1;
        lk_brop   <= brop_q[lk_sel];
        lk_jrop   <= jrop_q[lk_sel];
        lk_target <= {tgt[lk_sel], 2'b00};
      end else begin
        lk_hit    <= 1'b0;
        lk_idx    <= '0;
        lk_taken  <= 1'b0;
        lk_brop   <= 1'b0;
        lk_jrop   <= 1'b0;
        lk_target <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gs232c_btb_assoc.sv
// Bench for gs232c_btb_assoc: directed scenarios plus a short random phase.
// Expected lookup responses come from a reference table model and are queued
// when the lookup is driven, then compared when the response appears.
module tb_gs232c_btb_assoc;

  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int IW      = 4;
  localparam int W       = 1 + IW + 3 + 32;

  logic          clock;
  logic          resetn;
  logic          flush;
  logic          lk_valid;
  logic [31:0]   lk_pc;
  logic          lk_rsp;
  logic          lk_hit;
  logic [IW-1:0] lk_idx;
  logic          lk_taken;
  logic          lk_brop;
  logic          lk_jrop;
  logic [31:0]   lk_target;
  logic          up_valid;
  logic [31:0]   up_pc;
  logic          up_hit;
  logic [IW-1:0] up_idx;
  logic          up_taken;
  logic          up_brop;
  logic          up_jrop;
  logic [31:0]   up_target;

  gs232c_btb_assoc #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_rsp(lk_rsp), .lk_hit(lk_hit),
    .lk_idx(lk_idx), .lk_taken(lk_taken), .lk_brop(lk_brop), .lk_jrop(lk_jrop),
    .lk_target(lk_target), .up_valid(up_valid), .up_pc(up_pc), .up_hit(up_hit),
    .up_idx(up_idx), .up_taken(up_taken), .up_brop(up_brop), .up_jrop(up_jrop),
    .up_target(up_target)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference table
  bit          m_valid [ENTRIES];
  logic [29:0] m_tag   [ENTRIES];
  int          m_cnt   [ENTRIES];
  bit          m_brop  [ENTRIES];
  bit          m_jrop  [ENTRIES];
  logic [29:0] m_tgt   [ENTRIES];
  int          m_rr;

  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_lookup(input logic [31:0] pc, input logic fl);
    logic [W-1:0] r;
    r = '0;
    if (!fl) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (m_valid[i] && m_tag[i] == pc[31:2]) begin
          r = {1'b1, IW'(i), (m_brop[i] ? (m_cnt[i] >= 2) : 1'b1),
               m_brop[i], m_jrop[i], m_tgt[i], 2'b00};
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    m_rr = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input logic uh, input logic [IW-1:0] ui,
                              input logic t, input logic b, input logic j, input logic [31:0] tg);
    int e;
    e = -1;
    if (uh && m_valid[ui] && m_tag[ui] == pc[31:2]) e = int'(ui);
    else begin
      for (int i = 0; i < ENTRIES; i++)
        if (m_valid[i] && m_tag[i] == pc[31:2]) begin e = i; break; end
    end
    if (e >= 0) begin
      if (t) begin
        if (m_cnt[e] < 3) m_cnt[e]++;
        m_tgt[e] = tg[31:2]; m_brop[e] = b; m_jrop[e] = j;
      end else if (m_cnt[e] > 0) m_cnt[e]--;
    end else if (t) begin
      for (int i = 0; i < ENTRIES; i++)
        if (!m_valid[i]) begin e = i; break; end
      if (e < 0) begin e = m_rr; m_rr = (m_rr + 1) % ENTRIES; end
      m_valid[e] = 1; m_tag[e] = pc[31:2]; m_tgt[e] = tg[31:2];
      m_brop[e] = b; m_jrop[e] = j; m_cnt[e] = 2;
    end
  endtask

  // Driver: one clock of stimulus, applied at the falling edge.
  task automatic cycle(input logic fl, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc, input logic uh,
                       input logic [IW-1:0] ui, input logic t, input logic b,
                       input logic j, input logic [31:0] tg);
    flush = fl; lk_valid = lv; lk_pc = lpc;
    up_valid = uv; up_pc = upc; up_hit = uh; up_idx = ui;
    up_taken = t; up_brop = b; up_jrop = j; up_target = tg;
    if (lv) exp_q.push_back(model_lookup(lpc, fl));
    if (fl) model_reset();
    else if (uv) model_update(upc, uh, ui, t, b, j, tg);
    @(negedge clock);
    flush = 0; lk_valid = 0; up_valid = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    cycle(0, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic b, input logic j,
                        input logic [31:0] tg, input logic uh, input logic [IW-1:0] ui);
    cycle(0, 0, 0, 1, pc, uh, ui, t, b, j, tg);
  endtask

  task automatic do_reset();
    resetn = 0;
    exp_q.delete();
    model_reset();
    #1;
    check_val("reset_outputs", {lk_rsp, lk_hit, lk_idx, lk_taken, lk_brop, lk_jrop, lk_target}, '0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1;
  endtask

  // Directed check of the response currently held on the outputs.
  task automatic expect_rsp(input string tag, input logic h, input logic [IW-1:0] idx,
                            input logic tk, input logic [31:0] tg);
    check_val({tag, "_rsp"}, lk_rsp, 1'b1);
    check_val({tag, "_hit"}, lk_hit, h);
    check_val({tag, "_idx"}, lk_idx, idx);
    check_val({tag, "_taken"}, lk_taken, tk);
    check_val({tag, "_target"}, lk_target, tg);
  endtask

  // Scoreboard: compare each response one step after the edge it belongs to.
  always @(posedge clock) begin : monitor
    logic         v;
    logic [W-1:0] e;
    v = lk_valid && resetn;
    #1;
    if (resetn) begin
      if (v) begin
        check_val("rsp_valid", lk_rsp, 1'b1);
        check_val("q_size", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("rsp_data", {lk_hit, lk_idx, lk_taken, lk_brop, lk_jrop, lk_target}, e);
        end
      end else begin
        check_val("rsp_idle", lk_rsp, 1'b0);
      end
    end
  end

  function automatic logic [31:0] pc_k(input int k);
    return 32'h4000 + 32'(k * 4);
  endfunction

  initial begin
    flush = 0; lk_valid = 0; lk_pc = 0; up_valid = 0; up_pc = 0; up_hit = 0;
    up_idx = 0; up_taken = 0; up_brop = 0; up_jrop = 0; up_target = 0;
    resetn = 0;
    @(negedge clock);
    do_reset();

    // Empty table lookup
    lookup(32'h1000);
    expect_rsp("empty", 0, 0, 0, 0);
    check_val("empty_flags", {lk_brop, lk_jrop}, 2'b00);

    // Allocate then hit
    update(32'h1000, 1, 1, 0, 32'h2000, 0, 0);
    lookup(32'h1000);
    expect_rsp("alloc", 1, 0, 1, 32'h2000);

    // Counter training down to saturation at zero
    update(32'h1000, 0, 1, 0, 0, 1, 0);
    update(32'h1000, 0, 1, 0, 0, 1, 0);
    lookup(32'h1000);
    expect_rsp("nt2", 1, 0, 0, 32'h2000);
    update(32'h1000, 0, 1, 0, 0, 1, 0);
    update(32'h1000, 0, 1, 0, 0, 1, 0);
    update(32'h1000, 1, 1, 0, 32'h2000, 1, 0);
    lookup(32'h1000);
    expect_rsp("sat0", 1, 0, 0, 32'h2000);
    update(32'h1000, 1, 1, 0, 32'h2000, 1, 0);
    lookup(32'h1000);
    expect_rsp("retrain", 1, 0, 1, 32'h2000);

    // Same-edge update is not visible; indirect entry predicts taken
    cycle(0, 1, 32'h3000, 1, 32'h3000, 0, 0, 1, 0, 1, 32'h5004);
    expect_rsp("same_edge", 0, 0, 0, 0);
    lookup(32'h3000);
    expect_rsp("jr", 1, 1, 1, 32'h5004);
    check_val("jr_flag", lk_jrop, 1'b1);

    // Reset drops a pending response and clears a held one
    lk_valid = 1; lk_pc = 32'h1000;
    #2 resetn = 0;
    #1 check_val("rst_async", {lk_rsp, lk_hit, lk_target}, '0);
    lk_valid = 0;
    do_reset();
    lookup(32'h1000);
    expect_rsp("post_rst", 0, 0, 0, 0);
    update(32'h1000, 1, 1, 0, 32'h2000, 0, 0);
    lookup(32'h1000);
    resetn = 0;
    #1 check_val("rst_clear_rsp", {lk_rsp, lk_hit, lk_idx}, '0);
    do_reset();

    // Fill all entries, then the 17th replaces entry 0
    for (int k = 0; k < 17; k++) update(pc_k(k), 1, 1, 0, 32'h8000 + 32'(k * 16), 0, 0);
    lookup(pc_k(16));
    expect_rsp("repl17", 1, 0, 1, 32'h8100);
    lookup(pc_k(0));
    expect_rsp("evicted", 0, 0, 0, 0);
    lookup(pc_k(15));
    expect_rsp("last", 1, 15, 1, 32'h80f0);

    // Update without hint on entry 5, then with a stale hint
    update(pc_k(5), 0, 1, 0, 0, 0, 0);
    lookup(pc_k(5));
    expect_rsp("nohint", 1, 5, 0, 32'h8050);
    update(pc_k(5), 1, 1, 0, 32'h9000, 1, 3);
    lookup(pc_k(5));
    expect_rsp("stalehint", 1, 5, 1, 32'h9000);
    lookup(pc_k(3));
    expect_rsp("hint_untouched", 1, 3, 1, 32'h8030);

    // No duplicate was allocated, so rr still points at entry 1
    update(pc_k(17), 1, 1, 0, 32'h8110, 0, 0);
    lookup(pc_k(17));
    expect_rsp("rr1", 1, 1, 1, 32'h8110);

    // Flush with simultaneous taken miss and lookup of a held PC
    cycle(1, 1, pc_k(5), 1, 32'hA000, 0, 0, 1, 1, 0, 32'hB000);
    expect_rsp("flush_lk", 0, 0, 0, 0);
    lookup(32'hA000);
    expect_rsp("flush_noalloc", 0, 0, 0, 0);
    lookup(pc_k(5));
    expect_rsp("flush_gone", 0, 0, 0, 0);
    lookup(pc_k(16));
    expect_rsp("flush_gone2", 0, 0, 0, 0);

    // Random traffic over a PC set larger than the table
    for (int n = 0; n < 400; n++) begin
      int a, b;
      a = $urandom_range(23, 0);
      b = $urandom_range(23, 0);
      cycle(($urandom_range(49, 0) == 0), $urandom_range(1, 0), pc_k(a),
            $urandom_range(1, 0), pc_k(b), $urandom_range(1, 0),
            IW'($urandom_range(ENTRIES - 1, 0)), $urandom_range(1, 0),
            $urandom_range(1, 0), $urandom_range(1, 0),
            32'(($urandom_range(16'hffff, 0)) << 2));
    end

    @(negedge clock);
    @(negedge clock);
    check_val("q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
